// File: rtl/mips_multicycle_control.sv
// rtl/mips_multicycle_control.sv - Multi-cycle MIPS main controller FSM
//
// Sequences a shared-ALU, single-memory datapath through fetch, decode,
// execute, memory and writeback, one instruction at a time.
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   opcode[5:0]     IR[31:26], looked at only in DECODE and MEM_ADDR
//   mem_ready       memory access completes this cycle (FETCH/MEM_RD/MEM_WR)
//   pc_write, pc_write_cond, ir_write, reg_write, mem_write   write strobes
//   mem_read, i_or_d, mem_to_reg, reg_dst, alu_src_a          datapath muxes
//   alu_src_b[1:0]  00 B, 01 const 4, 10 imm, 11 imm<<2
//   alu_op[1:0]     00 add, 01 sub, 10 funct
//   pc_source[1:0]  00 ALU, 01 ALUOut, 10 jump target
//   illegal_op      unsupported opcode in DECODE
//   instr_done      pulse on the final cycle of each instruction
//   state[3:0]      current state (debug)

module mips_multicycle_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       mem_read,
    output logic       i_or_d,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic       instr_done,
    output logic [3:0] state
);

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC     = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ADDI_WB  = 4'd11
    } state_t;

    state_t cur_state;
    logic   op_legal;

    assign op_legal = (opcode == OP_RTYPE) || (opcode == OP_J)  ||
                      (opcode == OP_BEQ)   || (opcode == OP_ADDI) ||
                      (opcode == OP_LW)    || (opcode == OP_SW);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= S_FETCH;
        end else begin
            case (cur_state)
                S_FETCH:    if (mem_ready) cur_state <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW: cur_state <= S_MEM_ADDR;
                        OP_RTYPE:     cur_state <= S_EXEC;
                        OP_BEQ:       cur_state <= S_BRANCH;
                        OP_J:         cur_state <= S_JUMP;
                        OP_ADDI:      cur_state <= S_ADDI_EX;
                        default:      cur_state <= S_FETCH;
                    endcase
                end
                // A non-memory opcode here means IR changed under us; drop
                // the instruction rather than issue a stray access.
                S_MEM_ADDR: begin
                    if (opcode == OP_LW)      cur_state <= S_MEM_RD;
                    else if (opcode == OP_SW) cur_state <= S_MEM_WR;
                    else                      cur_state <= S_FETCH;
                end
                S_MEM_RD:   if (mem_ready) cur_state <= S_MEM_WB;
                S_MEM_WR:   if (mem_ready) cur_state <= S_FETCH;
                S_EXEC:     cur_state <= S_R_WB;
                S_ADDI_EX:  cur_state <= S_ADDI_WB;
                default:    cur_state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        mem_write     = 1'b0;
        mem_read      = 1'b0;
        i_or_d        = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        illegal_op    = 1'b0;
        instr_done    = 1'b0;
        case (cur_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                if (!op_legal) begin
                    illegal_op = 1'b1;
                    instr_done = 1'b1;
                end
            end
            S_MEM_ADDR, S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WR: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_R_WB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                instr_done    = 1'b1;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                instr_done = 1'b1;
            end
            S_ADDI_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
        // Reset must silence every strobe at once, even though FETCH would
        // otherwise follow mem_ready combinationally.
        if (!rst_n) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            ir_write      = 1'b0;
            reg_write     = 1'b0;
            mem_write     = 1'b0;
        end
    end

    assign state = cur_state;

endmodule
